// File: rtl/gauss_pkg.sv
// rtl/gauss_pkg.sv - shared constants and helpers for the Gaussian window and convolution stages
package gauss_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int MAX_COLS  = 220;
    localparam int MAX_ROWS  = 168;

    typedef enum int {
        KSIZE_3 = 3,
        KSIZE_5 = 5,
        KSIZE_7 = 7
    } ksize_e;

    function automatic bit is_legal_ksize(input int k);
        return (k == int'(KSIZE_3)) || (k == int'(KSIZE_5)) || (k == int'(KSIZE_7));
    endfunction

    // Flat element index of window element (r,c); r=0 is the oldest row, c=0 the leftmost column.
    function automatic int win_idx(input int r, input int c, input int k);
        return r * k + c;
    endfunction

endpackage

// File: rtl/gauss_line_buf.sv
// rtl/gauss_line_buf.sv - one-row pixel delay line with combinational read and same-address write
module gauss_line_buf #(
    parameter int DEPTH = 220,
    parameter int AW    = 8,
    parameter int PIX_W = 8
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [AW-1:0]    addr_i,
    input  logic [PIX_W-1:0] wdata_i,
    output logic [PIX_W-1:0] rdata_o
);

    logic [PIX_W-1:0] mem_q [DEPTH];

    // Read returns the value stored one row earlier, before this cycle's write lands.
    assign rdata_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (en_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

endmodule

// File: rtl/gauss_window_gen.sv
// rtl/gauss_window_gen.sv - raster pixel stream to KSIZE x KSIZE neighbourhood stream
module gauss_window_gen
    import gauss_pkg::*;
#(
    parameter int COLS  = 220,
    parameter int ROWS  = 168,
    parameter int KSIZE = 3,
    parameter int PIX_W = PIX_W_DEF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [PIX_W-1:0]            in_pixel,
    input  logic                        in_sof,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [KSIZE*KSIZE*PIX_W-1:0] out_window,
    output logic [7:0]                  out_row,
    output logic [7:0]                  out_col,
    output logic                        out_eof
);

    localparam int NLB = KSIZE - 1;
    localparam int WW  = KSIZE * KSIZE * PIX_W;
    localparam int AW  = $clog2(COLS);
    localparam logic [7:0] COL_LAST = 8'(COLS - 1);
    localparam logic [7:0] ROW_LAST = 8'(ROWS - 1);
    localparam logic [7:0] K_LAST   = 8'(KSIZE - 1);

    if (!is_legal_ksize(KSIZE)) begin : g_bad_ksize
        $error("gauss_window_gen: KSIZE must be 3, 5 or 7");
    end
    if (COLS > MAX_COLS || ROWS > MAX_ROWS || COLS < KSIZE || ROWS < KSIZE) begin : g_bad_frame
        $error("gauss_window_gen: frame size out of range");
    end

    logic [7:0]       col_q, col_d, row_q, row_d;
    logic [7:0]       cur_col, cur_row;
    logic             accept, complete;
    logic             out_valid_q, out_valid_d, out_eof_q, out_eof_d;
    logic [7:0]       out_row_q, out_row_d, out_col_q, out_col_d;
    logic [WW-1:0]    out_window_q, out_window_d, win_flat;
    logic [PIX_W-1:0] lb_wdata [NLB];
    logic [PIX_W-1:0] lb_rdata [NLB];
    logic [PIX_W-1:0] col_vec  [KSIZE];
    logic [PIX_W-1:0] sh_q     [KSIZE][KSIZE];
    logic [PIX_W-1:0] sh_d     [KSIZE][KSIZE];

    assign in_ready = !rst && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;
    // A start-of-frame pixel is always (0,0), whatever the counters held.
    assign cur_col  = in_sof ? 8'd0 : col_q;
    assign cur_row  = in_sof ? 8'd0 : row_q;
    assign complete = (cur_row >= K_LAST) && (cur_col >= K_LAST);

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == COL_LAST) begin
                col_d = 8'd0;
                row_d = (cur_row == ROW_LAST) ? 8'd0 : cur_row + 8'd1;
            end else begin
                col_d = cur_col + 8'd1;
                row_d = cur_row;
            end
        end
    end

    for (genvar i = 0; i < NLB; i++) begin : g_lb
        if (i == 0) begin : g_first
            assign lb_wdata[i] = in_pixel;
        end else begin : g_chain
            assign lb_wdata[i] = lb_rdata[i-1];
        end
        gauss_line_buf #(
            .DEPTH (COLS),
            .AW    (AW),
            .PIX_W (PIX_W)
        ) u_line_buf (
            .clk     (clk),
            .en_i    (accept),
            .addr_i  (cur_col[AW-1:0]),
            .wdata_i (lb_wdata[i]),
            .rdata_o (lb_rdata[i])
        );
        // Deeper buffers hold older rows, so the last buffer feeds window row 0.
        assign col_vec[NLB-1-i] = lb_rdata[i];
    end
    assign col_vec[KSIZE-1] = in_pixel;

    always_comb begin
        sh_d = sh_q;
        if (accept) begin
            for (int r = 0; r < KSIZE; r++) begin
                for (int c = 0; c < KSIZE - 1; c++) begin
                    sh_d[r][c] = sh_q[r][c+1];
                end
                sh_d[r][KSIZE-1] = col_vec[r];
            end
        end
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < KSIZE; r++) begin
            for (int c = 0; c < KSIZE; c++) begin
                win_flat[win_idx(r, c, KSIZE)*PIX_W +: PIX_W] = sh_d[r][c];
            end
        end
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_window_d = out_window_q;
        out_row_d    = out_row_q;
        out_col_d    = out_col_q;
        out_eof_d    = out_eof_q;
        if (accept && complete) begin
            out_valid_d  = 1'b1;
            out_window_d = win_flat;
            out_row_d    = cur_row - K_LAST;
            out_col_d    = cur_col - K_LAST;
            out_eof_d    = (cur_row == ROW_LAST) && (cur_col == COL_LAST);
        end else if (out_ready) begin
            out_valid_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            col_q        <= 8'd0;
            row_q        <= 8'd0;
            out_valid_q  <= 1'b0;
            out_window_q <= '0;
            out_row_q    <= 8'd0;
            out_col_q    <= 8'd0;
            out_eof_q    <= 1'b0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            out_valid_q  <= out_valid_d;
            out_window_q <= out_window_d;
            out_row_q    <= out_row_d;
            out_col_q    <= out_col_d;
            out_eof_q    <= out_eof_d;
        end
    end

    // Window contents need no reset: completion gating only exposes freshly shifted columns.
    always_ff @(posedge clk) begin
        sh_q <= sh_d;
    end

    assign out_valid  = out_valid_q;
    assign out_window = out_window_q;
    assign out_row    = out_row_q;
    assign out_col    = out_col_q;
    assign out_eof    = out_eof_q;

endmodule

// File: tb/tb_gauss_window_gen.sv
// tb/tb_gauss_window_gen.sv - directed bench for gauss_window_gen (5x4 KSIZE=3 and 220x168 KSIZE=7)
module tb_gauss_window_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst, in_valid, in_ready, in_sof, out_valid, out_ready, out_eof;
    logic [7:0]  in_pixel, out_row, out_col;
    logic [71:0] out_window;

    logic         rst7, in_valid7, in_ready7, in_sof7, out_valid7, out_ready7, out_eof7;
    logic [7:0]   in_pixel7, out_row7, out_col7;
    logic [391:0] out_window7;

    gauss_window_gen #(.COLS(5), .ROWS(4), .KSIZE(3), .PIX_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_pixel(in_pixel), .in_sof(in_sof), .out_valid(out_valid),
        .out_ready(out_ready), .out_window(out_window), .out_row(out_row),
        .out_col(out_col), .out_eof(out_eof)
    );

    gauss_window_gen #(.COLS(220), .ROWS(168), .KSIZE(7), .PIX_W(8)) dut7 (
        .clk(clk), .rst(rst7), .in_valid(in_valid7), .in_ready(in_ready7),
        .in_pixel(in_pixel7), .in_sof(in_sof7), .out_valid(out_valid7),
        .out_ready(out_ready7), .out_window(out_window7), .out_row(out_row7),
        .out_col(out_col7), .out_eof(out_eof7)
    );

    typedef struct packed {
        logic [71:0] w;
        logic [7:0]  r;
        logic [7:0]  c;
        logic        e;
    } cap_t;

    cap_t cap_q[$];

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) cap_q.push_back({out_window, out_row, out_col, out_eof});
    end

    function automatic logic [71:0] exp3(input logic [7:0] base, input int orow, input int ocol);
        logic [71:0] w;
        w = '0;
        for (int rr = 0; rr < 3; rr++)
            for (int cc = 0; cc < 3; cc++)
                w[(rr*3+cc)*8 +: 8] = base + 8'((orow + rr) * 16 + ocol + cc);
        return w;
    endfunction

    function automatic logic [7:0] pix7(input int r, input int c);
        return 8'(r * 3 + c * 7 + (r ^ c));
    endfunction

    function automatic logic [391:0] ref7(input int orow, input int ocol);
        logic [391:0] w;
        w = '0;
        for (int rr = 0; rr < 7; rr++)
            for (int cc = 0; cc < 7; cc++)
                w[(rr*7+cc)*8 +: 8] = pix7(orow + rr, ocol + cc);
        return w;
    endfunction

    task automatic send3(input logic [7:0] pix, input logic sof);
        int n;
        logic acc;
        in_valid = 1'b1; in_pixel = pix; in_sof = sof;
        n = 0; acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk); acc = in_ready;
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0; in_sof = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send3_timeout: pixel %h not accepted, in_ready=%b", pix, in_ready);
        end
    endtask

    task automatic send7(input logic [7:0] pix, input logic sof);
        int n;
        logic acc;
        in_valid7 = 1'b1; in_pixel7 = pix; in_sof7 = sof;
        n = 0; acc = 1'b0;
        while (!acc && n < 100) begin
            @(negedge clk); acc = in_ready7;
            @(posedge clk); #1; n++;
        end
        in_valid7 = 1'b0; in_sof7 = 1'b0;
        if (!acc) begin
            checks++; errors++;
            $display("FAIL send7_timeout: pixel %h not accepted, in_ready=%b", pix, in_ready7);
        end
    endtask

    task automatic send_frame3(input logic [7:0] base, input bit gaps);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
                send3(base + 8'(r * 16 + c), (r == 0 && c == 0));
            end
    endtask

    task automatic drain3();
        out_ready = 1'b1;
        repeat (4) begin @(posedge clk); #1; end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_pixel = '0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        checks++;
        if ({out_window, out_row, out_col, out_eof} !== '0)
            begin errors++; $display("FAIL reset_outputs: got %h/%h/%h/%b expected all 0", out_window, out_row, out_col, out_eof); end
        @(posedge clk); #1; rst = 1'b0;
    endtask

    task automatic test_basic();
        cap_q.delete();
        out_ready = 1'b1;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 5; c++) begin
                send3(8'(r * 16 + c), (r == 0 && c == 0));
                if (r == 2 && c == 1) begin
                    checks++;
                    if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_early_valid: got %b expected 0", out_valid); end
                end
                if (r == 2 && c == 2) begin
                    checks++;
                    if (out_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: out_valid got %b expected 1", out_valid); end
                    checks++;
                    if ({out_window, out_row, out_col} !== {72'h22_21_20_12_11_10_02_01_00, 8'd0, 8'd0})
                        begin errors++; $display("FAIL basic_first_window: got %h r%0d c%0d expected 222120121110020100 r0 c0", out_window, out_row, out_col); end
                end
            end
        drain3();
        checks++;
        if (cap_q.size() != 6) begin errors++; $display("FAIL basic_count: got %0d expected 6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)})
                begin errors++; $display("FAIL basic_window_%0d: got %h expected %h", i, cap_q[i], {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)}); end
        end
        if (cap_q.size() == 6) begin
            checks++;
            if (cap_q[5].w[71:64] !== 8'h34) begin errors++; $display("FAIL basic_eof_elem22: got %h expected 34", cap_q[5].w[71:64]); end
        end
    endtask

    task automatic test_backpressure();
        logic [88:0] snap;
        cap_q.delete();
        out_ready = 1'b0;
        fork
            send_frame3(8'h00, 1'b0);
            begin
                int n;
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 200) begin @(negedge clk); n++; end
                snap = {out_window, out_row, out_col, out_eof};
                checks++;
                if (snap !== {exp3(8'h00, 0, 0), 8'd0, 8'd0, 1'b0})
                    begin errors++; $display("FAIL stall_first: got %h expected %h", snap, {exp3(8'h00, 0, 0), 8'd0, 8'd0, 1'b0}); end
                repeat (5) begin
                    @(negedge clk);
                    checks++;
                    if ({out_valid, out_window, out_row, out_col, out_eof} !== {1'b1, snap})
                        begin errors++; $display("FAIL stall_stable: got %b %h expected 1 %h", out_valid, {out_window, out_row, out_col, out_eof}, snap); end
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_in_ready: got %b expected 0", in_ready); end
                end
                @(posedge clk); #1; out_ready = 1'b1;
            end
        join
        drain3();
        checks++;
        if (cap_q.size() != 6) begin errors++; $display("FAIL stall_count: got %0d expected 6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)})
                begin errors++; $display("FAIL stall_window_%0d: got %h expected %h", i, cap_q[i], {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)}); end
        end
    endtask

    task automatic test_random();
        bit done;
        cap_q.delete();
        done = 1'b0;
        fork
            begin send_frame3(8'h00, 1'b1); done = 1'b1; end
            begin
                int k;
                k = 0;
                while (!done && k < 3000) begin @(posedge clk); #1; out_ready = 1'($urandom_range(0, 1)); k++; end
            end
        join
        drain3();
        checks++;
        if (cap_q.size() != 6) begin errors++; $display("FAIL random_count: got %0d expected 6", cap_q.size()); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)})
                begin errors++; $display("FAIL random_window_%0d: got %h expected %h", i, cap_q[i], {exp3(8'h00, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)}); end
        end
    endtask

    task automatic test_sof_abort();
        int eofs;
        cap_q.delete();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send3(8'((i / 5) * 16 + i % 5), (i == 0));
        send_frame3(8'h80, 1'b0);
        drain3();
        checks++;
        if (cap_q.size() != 6) begin errors++; $display("FAIL abort_count: got %0d expected 6", cap_q.size()); end
        if (cap_q.size() > 0) begin
            checks++;
            if (cap_q[0].w !== 72'hA2_A1_A0_92_91_90_82_81_80)
                begin errors++; $display("FAIL abort_first_window: got %h expected A2A1A0929190828180", cap_q[0].w); end
        end
        eofs = 0;
        for (int i = 0; i < cap_q.size(); i++) if (cap_q[i].e) eofs++;
        checks++;
        if (eofs != 1) begin errors++; $display("FAIL abort_eof_count: got %0d expected 1", eofs); end
        for (int i = 0; i < 6 && i < cap_q.size(); i++) begin
            checks++;
            if (cap_q[i] !== {exp3(8'h80, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)})
                begin errors++; $display("FAIL abort_window_%0d: got %h expected %h", i, cap_q[i], {exp3(8'h80, i / 3, i % 3), 8'(i / 3), 8'(i % 3), (i == 5)}); end
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] base;
        int j;
        cap_q.delete();
        out_ready = 1'b1;
        send_frame3(8'h00, 1'b0);
        send_frame3(8'h80, 1'b0);
        drain3();
        checks++;
        if (cap_q.size() != 12) begin errors++; $display("FAIL b2b_count: got %0d expected 12", cap_q.size()); end
        for (int i = 0; i < 12 && i < cap_q.size(); i++) begin
            base = (i < 6) ? 8'h00 : 8'h80;
            j = i % 6;
            checks++;
            if (cap_q[i] !== {exp3(base, j / 3, j % 3), 8'(j / 3), 8'(j % 3), (j == 5)})
                begin errors++; $display("FAIL b2b_window_%0d: got %h expected %h", i, cap_q[i], {exp3(base, j / 3, j % 3), 8'(j / 3), 8'(j % 3), (j == 5)}); end
        end
    endtask

    task automatic test_reset_k7();
        int n;
        @(posedge clk); #1; rst7 = 1'b0; out_ready7 = 1'b0;
        in_valid7 = 1'b1; in_sof7 = 1'b1; n = 0;
        while (!out_valid7 && n < 3000) begin
            in_pixel7 = pix7(n / 220, n % 220);
            @(posedge clk); #1; in_sof7 = 1'b0; n++;
        end
        in_valid7 = 1'b0;
        checks++;
        if (out_valid7 !== 1'b1) begin errors++; $display("FAIL k7_pre_valid: got %b expected 1", out_valid7); end
        rst7 = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready7 !== 1'b0) begin errors++; $display("FAIL k7_rst_in_ready: got %b expected 0", in_ready7); end
        @(posedge clk); #1;
        checks++;
        if ({out_valid7, out_window7, out_row7, out_col7, out_eof7} !== '0)
            begin errors++; $display("FAIL k7_rst_outputs: valid %b row %h col %h eof %b window %h expected all 0", out_valid7, out_row7, out_col7, out_eof7, out_window7); end
        rst7 = 1'b0; out_ready7 = 1'b1;
        fork
            begin
                for (int r = 0; r < 168; r++)
                    for (int c = 0; c < 220; c++)
                        send7(pix7(r, c), (r == 0 && c == 0));
            end
            begin
                int k, orow, ocol;
                for (int w = 0; w < 162 * 214; w++) begin
                    k = 0;
                    @(negedge clk);
                    while (!(out_valid7 && out_ready7) && k < 2000) begin @(negedge clk); k++; end
                    if (k >= 2000) begin
                        checks++; errors++;
                        $display("FAIL k7_window_timeout: window %0d never appeared", w);
                        break;
                    end
                    orow = w / 214; ocol = w % 214;
                    checks++;
                    if ({out_window7, out_row7, out_col7, out_eof7} !== {ref7(orow, ocol), 8'(orow), 8'(ocol), (w == 162 * 214 - 1)})
                        begin errors++; $display("FAIL k7_window_%0d: got r%0d c%0d eof %b %h expected r%0d c%0d %h", w, out_row7, out_col7, out_eof7, out_window7, orow, ocol, ref7(orow, ocol)); end
                end
            end
        join
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (out_valid7 !== 1'b0) begin errors++; $display("FAIL k7_extra_window: out_valid got %b expected 0", out_valid7); end
        end
    endtask

    initial begin
        rst7 = 1'b1; in_valid7 = 1'b0; in_sof7 = 1'b0; in_pixel7 = '0; out_ready7 = 1'b0;
        test_reset();
        test_basic();
        test_backpressure();
        test_random();
        test_sof_abort();
        test_back_to_back();
        test_reset_k7();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
